// File: rtl/pe_cube_pkg.sv
// Shared constants, state encoding and helpers for the PE cube result path.
package pe_cube_pkg;

    localparam int CUBE_NUM_DEF  = 3;
    localparam int BLOCK_NUM_DEF = 3;
    localparam int ARRAY_NUM_DEF = 3;
    localparam int BYTE_W        = 8;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } drain_state_e;

    // Ceiling log2, never below 1 so an index always has at least one bit.
    function automatic int clog2_f(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        if (res == 0) begin
            res = 1;
        end else begin
            res = res;
        end
        return res;
    endfunction

endpackage

// File: rtl/pe_beat_mux.sv
// Combinational beat selector: picks beat iIdx out of the packed shadow vector.
module pe_beat_mux #(
    parameter int BEATS  = 9,
    parameter int BEAT_W = 24,
    parameter int IDX_W  = 4
) (
    input  logic [BEATS*BEAT_W-1:0] iVec,
    input  logic [IDX_W-1:0]        iIdx,
    output logic [BEAT_W-1:0]       oBeat
);

    logic [31:0]             shamt_s;
    logic [BEATS*BEAT_W-1:0] shifted_s;

    // Beat k lives at bit offset k*BEAT_W; out-of-range indices shift to zero.
    always_comb begin
        shamt_s   = 32'(iIdx) * 32'(BEAT_W);
        shifted_s = iVec >> shamt_s;
        oBeat     = shifted_s[BEAT_W-1:0];
    end

endmodule

// File: rtl/pe_result_drain.sv
// Snapshots the cube result vector on a capture strobe and streams it out
// as ARRAY_NUM-byte beats over valid/ready, clearing the cube accumulators
// as soon as the snapshot is taken.
module pe_result_drain
    import pe_cube_pkg::*;
#(
    parameter int CUBE_NUM  = CUBE_NUM_DEF,
    parameter int BLOCK_NUM = BLOCK_NUM_DEF,
    parameter int ARRAY_NUM = ARRAY_NUM_DEF,
    localparam int BEATS    = BLOCK_NUM * CUBE_NUM,
    localparam int IDX_W    = clog2_f(BEATS),
    localparam int BEAT_W   = BYTE_W * ARRAY_NUM,
    localparam int VEC_W    = BEAT_W * BEATS
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [VEC_W-1:0]  iResult,
    input  logic              iCapture,
    output logic              oCaptureReady,
    output logic              oClearAcc,
    output logic [BEAT_W-1:0] oData,
    output logic              oValid,
    input  logic              iReady,
    output logic              oLast,
    output logic [IDX_W-1:0]  oBeatIdx,
    output logic              oOverrun,
    input  logic              iClearOverrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    drain_state_e      state_q, state_d;
    logic [VEC_W-1:0]  shadow_q, shadow_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [BEAT_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              clear_q, clear_d;
    logic              overrun_q, overrun_d;

    logic              cap_ready_s;
    logic              accept_s;
    logic              drop_s;
    logic              xfer_s;
    logic [BEAT_W-1:0] mux_beat_s;

    // The mux looks at next-cycle shadow/index so oData can be registered
    // and still show beat 0 on the cycle right after a capture.
    pe_beat_mux #(
        .BEATS  (BEATS),
        .BEAT_W (BEAT_W),
        .IDX_W  (IDX_W)
    ) u_beat_mux (
        .iVec  (shadow_d),
        .iIdx  (idx_d),
        .oBeat (mux_beat_s)
    );

    // Capture acceptance: always in IDLE, otherwise only on the final handshake.
    always_comb begin
        cap_ready_s = 1'b0;
        case (state_q)
            ST_IDLE:   cap_ready_s = 1'b1;
            ST_STREAM: cap_ready_s = valid_q & iReady & last_q;
            default:   cap_ready_s = 1'b0;
        endcase
        accept_s = iCapture & cap_ready_s;
        drop_s   = iCapture & ~cap_ready_s;
        xfer_s   = valid_q & iReady;
    end

    // Next-state, beat sequencing, clear pulse and sticky overrun.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        clear_d   = 1'b0;
        overrun_d = overrun_q;

        if (accept_s) begin
            shadow_d = iResult;
            idx_d    = {IDX_W{1'b0}};
            valid_d  = 1'b1;
            clear_d  = 1'b1;
            state_d  = ST_STREAM;
        end else if (xfer_s) begin
            if (last_q) begin
                idx_d   = {IDX_W{1'b0}};
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end else begin
                idx_d = idx_q + IDX_W'(1'b1);
            end
        end else begin
            idx_d = idx_q;
        end

        // A dropped capture outranks a simultaneous clear request.
        if (drop_s) begin
            overrun_d = 1'b1;
        end else if (iClearOverrun) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        last_d = valid_d & (idx_d == LAST_IDX);
        if (valid_d) begin
            data_d = mux_beat_s;
        end else begin
            data_d = {BEAT_W{1'b0}};
        end
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q   <= ST_IDLE;
            shadow_q  <= {VEC_W{1'b0}};
            idx_q     <= {IDX_W{1'b0}};
            data_q    <= {BEAT_W{1'b0}};
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            clear_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            clear_q   <= clear_d;
            overrun_q <= overrun_d;
        end
    end

    assign oCaptureReady = cap_ready_s;
    assign oClearAcc     = clear_q;
    assign oData         = data_q;
    assign oValid        = valid_q;
    assign oLast         = last_q;
    assign oBeatIdx      = idx_q;
    assign oOverrun      = overrun_q;

endmodule

// File: tb/tb_pe_result_drain.sv
// Self-checking bench for pe_result_drain: directed scenarios plus a
// randomized run, all checked against a frame-level reference model.
module tb_pe_result_drain;

    localparam int BEATS  = 9;
    localparam int BEAT_W = 24;
    localparam int VEC_W  = 216;
    localparam int IDX_W  = 4;

    logic              iClk = 1'b0;
    logic              iRst = 1'b0;
    logic [VEC_W-1:0]  iResult = '0;
    logic              iCapture = 1'b0;
    logic              iReady = 1'b0;
    logic              iClearOverrun = 1'b0;
    logic              oCaptureReady;
    logic              oClearAcc;
    logic [BEAT_W-1:0] oData;
    logic              oValid;
    logic              oLast;
    logic [IDX_W-1:0]  oBeatIdx;
    logic              oOverrun;

    int total = 0;
    int bad   = 0;

    // Reference model: frame contents, position in frame, sticky flag.
    bit               m_valid = 1'b0;
    int               m_idx   = 0;
    logic [VEC_W-1:0] m_frame = '0;
    bit               m_ovr   = 1'b0;
    bit               m_clr   = 1'b0;

    pe_result_drain dut (
        .iClk          (iClk),
        .iRst          (iRst),
        .iResult       (iResult),
        .iCapture      (iCapture),
        .oCaptureReady (oCaptureReady),
        .oClearAcc     (oClearAcc),
        .oData         (oData),
        .oValid        (oValid),
        .iReady        (iReady),
        .oLast         (oLast),
        .oBeatIdx      (oBeatIdx),
        .oOverrun      (oOverrun),
        .iClearOverrun (iClearOverrun)
    );

    always #5 iClk = ~iClk;

    // Beat k = bytes 3k+2, 3k+1, 3k of the frame, MSB to LSB.
    function automatic logic [BEAT_W-1:0] ref_beat(input logic [VEC_W-1:0] f, input int k);
        logic [7:0] b0, b1, b2;
        b0 = f[8*(3*k)   +: 8];
        b1 = f[8*(3*k+1) +: 8];
        b2 = f[8*(3*k+2) +: 8];
        return {b2, b1, b0};
    endfunction

    function automatic logic [VEC_W-1:0] ramp(input logic [7:0] base);
        logic [VEC_W-1:0] v;
        v = '0;
        for (int n = 0; n < 27; n++) v[8*n +: 8] = base + 8'(n);
        return v;
    endfunction

    function automatic logic [VEC_W-1:0] rand_vec();
        logic [VEC_W-1:0] v;
        v = '0;
        for (int n = 0; n < 27; n++) v[8*n +: 8] = 8'($urandom_range(0, 255));
        return v;
    endfunction

    // Drive one cycle of inputs (called at a negedge) and advance the model.
    task automatic step(input bit cap, input logic [VEC_W-1:0] res, input bit rdy, input bit clr);
        bit cr, acc, drop;
        iCapture = cap; iResult = res; iReady = rdy; iClearOverrun = clr;
        cr   = !m_valid || (rdy && m_idx == BEATS-1);
        acc  = cap && cr;
        drop = cap && !cr;
        @(negedge iClk);
        m_clr = acc;
        if (acc) begin
            m_frame = res; m_idx = 0; m_valid = 1'b1;
        end else if (m_valid && rdy) begin
            if (m_idx == BEATS-1) begin m_valid = 1'b0; m_idx = 0; end
            else m_idx = m_idx + 1;
        end
        if (drop) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        iCapture = 1'b0; iClearOverrun = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge iClk);
        @(negedge iClk);
        total++; if (oValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", oValid); end
        total++; if (oLast !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", oLast); end
        total++; if (oBeatIdx !== 4'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", oBeatIdx); end
        total++; if (oData !== 24'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", oData); end
        total++; if (oClearAcc !== 1'b0) begin bad++; $display("FAIL reset_clr got=%b exp=0", oClearAcc); end
        total++; if (oOverrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b exp=0", oOverrun); end
        total++; if (oCaptureReady !== 1'b1) begin bad++; $display("FAIL reset_capready got=%b exp=1", oCaptureReady); end
        iRst = 1'b1;
        @(negedge iClk);
    endtask

    task automatic test_single_frame();
        logic [BEAT_W-1:0] exp;
        int clr_cnt;
        clr_cnt = 0;
        step(1'b1, ramp(8'h00), 1'b1, 1'b0);
        for (int k = 0; k < BEATS; k++) begin
            exp = {8'(3*k+2), 8'(3*k+1), 8'(3*k)};
            if (oClearAcc === 1'b1) clr_cnt++;
            total++; if (oValid !== 1'b1) begin bad++; $display("FAIL single_valid k=%0d got=%b exp=1", k, oValid); end
            total++; if (oBeatIdx !== 4'(k)) begin bad++; $display("FAIL single_idx got=%0d exp=%0d", oBeatIdx, k); end
            total++; if (oData !== exp) begin bad++; $display("FAIL single_data k=%0d got=%h exp=%h", k, oData, exp); end
            total++; if (oLast !== (k == BEATS-1)) begin bad++; $display("FAIL single_last k=%0d got=%b", k, oLast); end
            total++; if (oClearAcc !== (k == 0)) begin bad++; $display("FAIL single_clracc k=%0d got=%b", k, oClearAcc); end
            step(1'b0, rand_vec(), 1'b1, 1'b0);
        end
        total++; if (clr_cnt != 1) begin bad++; $display("FAIL single_clrcount got=%0d exp=1", clr_cnt); end
        total++; if (oValid !== 1'b0) begin bad++; $display("FAIL single_idle_valid got=%b exp=0", oValid); end
        total++; if (oCaptureReady !== 1'b1) begin bad++; $display("FAIL single_idle_capready got=%b exp=1", oCaptureReady); end
    endtask

    task automatic test_stall();
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [BEAT_W-1:0] got [$];
        logic [BEAT_W-1:0] exp;
        int cyc;
        bit rdy;
        step(1'b1, ramp(8'h00), 1'b1, 1'b0);
        cyc = 0;
        while (m_valid && cyc < 60) begin
            rdy = pat[cyc % 4];
            total++; if (oValid !== 1'b1) begin bad++; $display("FAIL stall_valid cyc=%0d got=%b exp=1", cyc, oValid); end
            total++; if (oBeatIdx !== 4'(m_idx)) begin bad++; $display("FAIL stall_idx got=%0d exp=%0d", oBeatIdx, m_idx); end
            total++; if (oData !== ref_beat(m_frame, m_idx)) begin bad++; $display("FAIL stall_data got=%h exp=%h", oData, ref_beat(m_frame, m_idx)); end
            if (rdy && oValid === 1'b1) got.push_back(oData);
            step(1'b0, rand_vec(), rdy, 1'b0);
            cyc++;
        end
        total++; if (cyc >= 60) begin bad++; $display("FAIL stall_timeout got=%0d exp<60", cyc); end
        total++; if (got.size() != BEATS) begin bad++; $display("FAIL stall_count got=%0d exp=%0d", got.size(), BEATS); end
        for (int k = 0; k < BEATS && k < got.size(); k++) begin
            exp = {8'(3*k+2), 8'(3*k+1), 8'(3*k)};
            total++; if (got[k] !== exp) begin bad++; $display("FAIL stall_order k=%0d got=%h exp=%h", k, got[k], exp); end
        end
    endtask

    task automatic test_overrun();
        step(1'b1, rand_vec(), 1'b1, 1'b0);
        for (int k = 0; k < BEATS; k++) begin
            total++; if (oBeatIdx !== 4'(k)) begin bad++; $display("FAIL ovr_idx got=%0d exp=%0d", oBeatIdx, k); end
            total++; if (oData !== ref_beat(m_frame, k)) begin bad++; $display("FAIL ovr_data k=%0d got=%h exp=%h", k, oData, ref_beat(m_frame, k)); end
            total++; if (oClearAcc !== m_clr) begin bad++; $display("FAIL ovr_clracc k=%0d got=%b exp=%b", k, oClearAcc, m_clr); end
            total++; if (oOverrun !== m_ovr) begin bad++; $display("FAIL ovr_flag k=%0d got=%b exp=%b", k, oOverrun, m_ovr); end
            step(k == 4, rand_vec(), 1'b1, 1'b0);
        end
        total++; if (oOverrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", oOverrun); end
        step(1'b0, rand_vec(), 1'b1, 1'b1);
        total++; if (oOverrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", oOverrun); end
    endtask

    task automatic test_back_to_back();
        logic [BEAT_W-1:0] exp;
        step(1'b1, ramp(8'h00), 1'b1, 1'b0);
        for (int k = 0; k < BEATS-1; k++) step(1'b0, rand_vec(), 1'b1, 1'b0);
        total++; if (oLast !== 1'b1) begin bad++; $display("FAIL b2b_last got=%b exp=1", oLast); end
        iReady = 1'b1;
        #1;
        total++; if (oCaptureReady !== 1'b1) begin bad++; $display("FAIL b2b_capready got=%b exp=1", oCaptureReady); end
        step(1'b1, ramp(8'hA0), 1'b1, 1'b0);
        for (int k = 0; k < BEATS; k++) begin
            exp = {8'hA0 + 8'(3*k+2), 8'hA0 + 8'(3*k+1), 8'hA0 + 8'(3*k)};
            total++; if (oValid !== 1'b1) begin bad++; $display("FAIL b2b_valid k=%0d got=%b exp=1", k, oValid); end
            total++; if (oData !== exp) begin bad++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, oData, exp); end
            total++; if (oClearAcc !== (k == 0)) begin bad++; $display("FAIL b2b_clracc k=%0d got=%b", k, oClearAcc); end
            total++; if (oOverrun !== 1'b0) begin bad++; $display("FAIL b2b_ovr k=%0d got=%b exp=0", k, oOverrun); end
            step(1'b0, rand_vec(), 1'b1, 1'b0);
        end
    endtask

    task automatic test_reset_midstream();
        step(1'b1, rand_vec(), 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, rand_vec(), 1'b1, 1'b0);
        total++; if (oBeatIdx !== 4'd5) begin bad++; $display("FAIL rstmid_pre_idx got=%0d exp=5", oBeatIdx); end
        #2 iRst = 1'b0;
        #1;
        m_valid = 1'b0; m_idx = 0; m_ovr = 1'b0; m_clr = 1'b0;
        total++; if (oValid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", oValid); end
        total++; if (oData !== 24'd0) begin bad++; $display("FAIL rstmid_data got=%h exp=0", oData); end
        total++; if (oBeatIdx !== 4'd0) begin bad++; $display("FAIL rstmid_idx got=%0d exp=0", oBeatIdx); end
        total++; if (oLast !== 1'b0) begin bad++; $display("FAIL rstmid_last got=%b exp=0", oLast); end
        @(negedge iClk);
        iRst = 1'b1;
        iReady = 1'b0;
        #1;
        total++; if (oCaptureReady !== 1'b1) begin bad++; $display("FAIL rstmid_capready got=%b exp=1", oCaptureReady); end
        step(1'b1, rand_vec(), 1'b1, 1'b0);
        for (int k = 0; k < BEATS; k++) begin
            total++; if (oBeatIdx !== 4'(k)) begin bad++; $display("FAIL rstmid_new_idx got=%0d exp=%0d", oBeatIdx, k); end
            total++; if (oData !== ref_beat(m_frame, k)) begin bad++; $display("FAIL rstmid_new_data k=%0d got=%h exp=%h", k, oData, ref_beat(m_frame, k)); end
            step(1'b0, rand_vec(), 1'b1, 1'b0);
        end
    endtask

    task automatic test_clear_same_cycle();
        step(1'b1, rand_vec(), 1'b0, 1'b0);
        step(1'b1, rand_vec(), 1'b0, 1'b1);
        total++; if (oOverrun !== 1'b1) begin bad++; $display("FAIL sameclr_ovr got=%b exp=1", oOverrun); end
        total++; if (oClearAcc !== 1'b0) begin bad++; $display("FAIL sameclr_clracc got=%b exp=0", oClearAcc); end
        total++; if (oData !== ref_beat(m_frame, 0)) begin bad++; $display("FAIL sameclr_data got=%h exp=%h", oData, ref_beat(m_frame, 0)); end
        while (m_valid) step(1'b0, rand_vec(), 1'b1, 1'b0);
        step(1'b0, rand_vec(), 1'b1, 1'b1);
        total++; if (oOverrun !== 1'b0) begin bad++; $display("FAIL sameclr_release got=%b exp=0", oOverrun); end
    endtask

    task automatic test_random();
        bit cap, rdy, clr, exp_cr;
        for (int c = 0; c < 400; c++) begin
            total++; if (oValid !== m_valid) begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, oValid, m_valid); end
            if (m_valid) begin
                total++; if (oBeatIdx !== 4'(m_idx)) begin bad++; $display("FAIL rnd_idx c=%0d got=%0d exp=%0d", c, oBeatIdx, m_idx); end
                total++; if (oData !== ref_beat(m_frame, m_idx)) begin bad++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, oData, ref_beat(m_frame, m_idx)); end
            end
            total++; if (oLast !== (m_valid && m_idx == BEATS-1)) begin bad++; $display("FAIL rnd_last c=%0d got=%b", c, oLast); end
            total++; if (oClearAcc !== m_clr) begin bad++; $display("FAIL rnd_clracc c=%0d got=%b exp=%b", c, oClearAcc, m_clr); end
            total++; if (oOverrun !== m_ovr) begin bad++; $display("FAIL rnd_ovr c=%0d got=%b exp=%b", c, oOverrun, m_ovr); end
            cap = ($urandom_range(0, 5) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            iReady = rdy;
            #1;
            exp_cr = !m_valid || (rdy && m_idx == BEATS-1);
            total++; if (oCaptureReady !== exp_cr) begin bad++; $display("FAIL rnd_capready c=%0d got=%b exp=%b", c, oCaptureReady, exp_cr); end
            step(cap, rand_vec(), rdy, clr);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_stall();
        test_overrun();
        test_back_to_back();
        test_reset_midstream();
        test_clear_same_cycle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_result_drain.md
Name: pe_result_drain

Overview:
- Read-side companion of the PE cube: snapshots the cube's wide result vector on a capture strobe and streams it out as ARRAY_NUM-byte beats over a valid/ready interface.
- Sits between the cube result bus and the output buffer / writeback path.
- Issues the accumulator-clear pulse back to the cube once the snapshot is taken, so the next tile can accumulate while the current one drains.

Parameters:
- CUBE_NUM, 3, number of PE blocks in the cube.
- BLOCK_NUM, 3, blocks per cube row group.
- ARRAY_NUM, 3, PE arrays per block; also bytes per output beat.
- Derived (localparam): BEATS = BLOCK_NUM*CUBE_NUM (default 9); IDX_W = clog2(BEATS) (default 4).

Ports:
- iClk  in  1  clock; all logic on the rising edge.
- iRst  in  1  asynchronous, active-low reset.
- iResult  in  8*ARRAY_NUM*BLOCK_NUM*CUBE_NUM  cube result vector.
- iCapture  in  1  one-cycle strobe: snapshot iResult this cycle.
- oCaptureReady  out  1  high when a capture this cycle will be accepted.
- oClearAcc  out  1  one-cycle pulse to the cube's iClearAcc after an accepted capture.
- oData  out  8*ARRAY_NUM  current beat.
- oValid  out  1  beat valid.
- iReady  in  1  downstream accepts the beat.
- oLast  out  1  marks beat BEATS-1.
- oBeatIdx  out  IDX_W  index of the current beat.
- oOverrun  out  1  sticky: a capture was dropped.
- iClearOverrun  in  1  synchronous clear of oOverrun.

Behaviour:
- Reset (iRst=0, asynchronous): state=IDLE; oValid=0, oLast=0, oBeatIdx=0, oData=0, oClearAcc=0, oOverrun=0, shadow register=0.
- States and transitions:
  - IDLE: oCaptureReady=1; iCapture -> STREAM.
  - STREAM: oCaptureReady = oValid & iReady & oLast (capture chains onto the final handshake).
  - Final handshake without capture -> IDLE.
- Accepted capture at edge t:
  - shadow <= iResult.
  - At t+1: oValid=1, oBeatIdx=0, oData=shadow beat 0, oClearAcc=1 for exactly one cycle.
- Beat k = shadow[8*ARRAY_NUM*k +: 8*ARRAY_NUM] (block-major, matching the cube's result layout). Beat 0 is first.
- Handshake: a beat transfers when oValid & iReady. On transfer, oBeatIdx increments and oData advances next cycle.
- While oValid & !iReady, oData, oBeatIdx and oLast are held stable. oValid never drops before transfer.
- oLast = oValid & (oBeatIdx==BEATS-1).
- Throughput: one beat per cycle with iReady held high. Capture-to-last-beat = BEATS cycles; no bubble between back-to-back frames when the capture coincides with the last handshake.
- Capture while oCaptureReady=0:
  - Capture is dropped; shadow and stream are untouched; no oClearAcc.
  - oOverrun <= 1 (sticky).
- iClearOverrun and a dropped capture in the same cycle: set wins.
- Reset asserted mid-stream: frame is abandoned, all outputs return to reset values immediately; no partial frame resumes after reset.
- oData is registered; no combinational path from iResult or iReady to oData. oCaptureReady may depend combinationally on iReady.

Decomposition:
- Shared package (pe_cube_pkg):
  - Default CUBE_NUM/BLOCK_NUM/ARRAY_NUM.
  - Byte width constant 8.
  - State encoding for IDLE/STREAM.
  - Clog2 helper for IDX_W.
- One natural sub-module: pe_beat_mux. It is combinational BEATS:1 selection of the shadow register by beat index. Instantiate it once, and register its output in the parent.

Test Plan:
- Reset then capture iResult with byte n = n (n=0..26), iReady=1:
  - oClearAcc pulses once at t+1.
  - Beats 0..8 arrive on 9 consecutive cycles; beat k = {3k+2, 3k+1, 3k} as bytes, MSB to LSB.
  - oLast is high only on beat 8; then return to IDLE.
- Same frame with iReady toggling 1,0,0,1,…: every beat is delivered exactly once, in order; oData and oBeatIdx are stable during stalls.
- iCapture at beat 4 of a stream:
  - Capture is dropped and oOverrun=1.
  - Stream continues unchanged; no extra oClearAcc.
  - iClearOverrun then returns oOverrun to 0.
- Second capture (bytes = 0xA0+n) coinciding with the beat-8 handshake: next cycle shows beat 0 of the new frame = {0xA2, 0xA1, 0xA0}; no idle gap; a second oClearAcc pulse.
- iRst low during beat 5: outputs are 0 immediately. After release, oCaptureReady=1 and a new capture streams from beat 0.
- iClearOverrun asserted in the same cycle as a dropped capture -> oOverrun=1.
